// File: rtl/seven_seg_mux_driver_if.sv
// Display-side bundle for the 7-segment scan driver: capture controls, nibble data
// and the active-low segment/anode pins.
interface seven_seg_mux_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    en;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp;
  logic                    lz_blank;
  logic [6:0]              seg_n;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   an_n;

  modport master (
    output en, load, value, dp, lz_blank,
    input  seg_n, dp_n, an_n
  );

  modport slave (
    input  en, load, value, dp, lz_blank,
    output seg_n, dp_n, an_n
  );
endinterface

// File: rtl/seven_seg_mux_driver.sv
// Time-multiplexed common-anode 7-segment driver with shadowed data, per-slot
// anode dead time, hex/BCD decode, decimal points and leading-zero blanking.
module seven_seg_mux_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 10000,
  parameter int BLANK_CYCLES = 16,
  parameter int HEX_MODE     = 0
) (
  input logic                    clk,
  input logic                    rst_n,
  seven_seg_mux_driver_if.slave  bus
);
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [4*NUM_DIGITS-1:0] val_q, val_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dpn_q, dpn_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic [3:0] nib;
  logic       dp_sel;
  logic       blank_sel;
  logic       upper_zero;

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'h0:    pat = 7'b0000001;
      4'h1:    pat = 7'b1001111;
      4'h2:    pat = 7'b0010010;
      4'h3:    pat = 7'b0000110;
      4'h4:    pat = 7'b1001100;
      4'h5:    pat = 7'b0100100;
      4'h6:    pat = 7'b0100000;
      4'h7:    pat = 7'b0001111;
      4'h8:    pat = 7'b0000000;
      4'h9:    pat = 7'b0000100;
      4'hA:    pat = (HEX_MODE != 0) ? 7'b0001000 : 7'b1111110;
      4'hB:    pat = (HEX_MODE != 0) ? 7'b1100000 : 7'b1111110;
      4'hC:    pat = (HEX_MODE != 0) ? 7'b0110001 : 7'b1111110;
      4'hD:    pat = (HEX_MODE != 0) ? 7'b1000010 : 7'b1111110;
      4'hE:    pat = (HEX_MODE != 0) ? 7'b0110000 : 7'b1111110;
      default: pat = (HEX_MODE != 0) ? 7'b0111000 : 7'b1111110;
    endcase
    return pat;
  endfunction

  always_comb begin
    val_d = val_q;
    dp_d  = dp_q;
    if (bus.load) begin
      val_d = bus.value;
      dp_d  = bus.dp;
    end

    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!bus.en) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Walk from the top digit down so upper_zero covers nibbles i..NUM_DIGITS-1.
    upper_zero = 1'b1;
    nib        = '0;
    dp_sel     = 1'b0;
    blank_sel  = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (val_q[4*i +: 4] == 4'd0);
      if (IDX_W'(i) == idx_q) begin
        nib       = val_q[4*i +: 4];
        dp_sel    = dp_q[i];
        blank_sel = bus.lz_blank && upper_zero && (i != 0);
      end
    end

    // Segments carry the new digit through the dead time; only the anode waits.
    seg_d = 7'h7F;
    dpn_d = 1'b1;
    an_d  = '1;
    if (bus.en) begin
      seg_d = blank_sel ? 7'h7F : decode(nib);
      dpn_d = ~dp_sel;
      if (int'(cnt_q) >= BLANK_CYCLES) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (IDX_W'(i) == idx_q) an_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= '0;
      dp_q  <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      seg_q <= 7'h7F;
      dpn_q <= 1'b1;
      an_q  <= '1;
    end else begin
      val_q <= val_d;
      dp_q  <= dp_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      dpn_q <= dpn_d;
      an_q  <= an_d;
    end
  end

  assign bus.seg_n = seg_q;
  assign bus.dp_n  = dpn_q;
  assign bus.an_n  = an_q;
endmodule
